// File: rtl/bus_arbiter_pkg.sv
// Shared constants, encodings and payload types for the bus arbiter.
package bus_arbiter_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned FIFO_AW = 2;
  localparam int unsigned FIFO_DW = 8;

  localparam int unsigned     RAM_AW_DEF      = 10;
  localparam logic [REG_W-1:0] RAM_REGION_DEF  = 4'h0;
  localparam logic [REG_W-1:0] FIFO_REGION_DEF = 4'h8;

  // Master encodings, also used as the round-robin history value
  typedef enum logic {
    GNT_INSTR = 1'b0,
    GNT_DATA  = 1'b1
  } gnt_e;

  // Source of response data; stores and errors return zero
  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_RAM  = 2'd1,
    TGT_FIFO = 2'd2
  } tgt_e;

  // One-entry response register payload
  typedef struct packed {
    logic valid;
    gnt_e master;
    tgt_e target;
    logic err;
  } rsp_t;

  // Region field used for target decode
  function automatic logic [REG_W-1:0] region_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: REG_W];
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// Two-master (fetch / load-store) arbiter with RAM / fifo_if decode and a
// single-entry response register returning data one cycle after acceptance.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned      RAM_AW      = RAM_AW_DEF,
  parameter logic [REG_W-1:0] RAM_REGION  = RAM_REGION_DEF,
  parameter logic [REG_W-1:0] FIFO_REGION = FIFO_REGION_DEF
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  // fetch port
  input  logic                i_req_i,
  input  logic [ADDR_W-1:0]   i_addr_i,
  output logic                i_gnt_o,
  output logic                i_rvalid_o,
  output logic [DATA_W-1:0]   i_rdata_o,
  output logic                i_err_o,
  // load/store port
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [BE_W-1:0]     d_be_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                d_err_o,
  // RAM
  output logic                ram_en_o,
  output logic [BE_W-1:0]     ram_we_o,
  output logic [RAM_AW-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_wdata_o,
  input  logic [DATA_W-1:0]   ram_rdata_i,
  // fifo_if registers
  output logic                fifo_sel_o,
  output logic                fifo_read_o,
  output logic                fifo_write_o,
  output logic [FIFO_AW-1:0]  fifo_addr_o,
  output logic [FIFO_DW-1:0]  fifo_data_o,
  input  logic [FIFO_DW-1:0]  fifo_data_i
);

  gnt_e              last_gnt_q, last_gnt_d;
  rsp_t              rsp_q, rsp_d;

  logic              contended_c;
  logic              gnt_i_c, gnt_d_c, any_gnt_c, store_c;
  logic [ADDR_W-1:0] addr_c;
  tgt_e              tgt_c;
  logic              err_c;
  logic [DATA_W-1:0] rsp_data_c;
  logic              unused_addr_c;

  // Round-robin grant; history moves only when both masters contend
  always_comb begin
    contended_c = 1'b0;
    gnt_i_c     = 1'b0;
    gnt_d_c     = 1'b0;
    last_gnt_d  = last_gnt_q;
    if (rstn_i) begin
      contended_c = i_req_i & d_req_i;
      gnt_d_c     = d_req_i & (~i_req_i | (last_gnt_q == GNT_INSTR));
      gnt_i_c     = i_req_i & ~gnt_d_c;
      if (contended_c) begin
        last_gnt_d = gnt_d_c ? GNT_DATA : GNT_INSTR;
      end
    end
  end

  // Target decode of the granted request; fetches are word-aligned RAM only
  always_comb begin
    addr_c    = gnt_d_c ? d_addr_i : i_addr_i;
    any_gnt_c = gnt_i_c | gnt_d_c;
    store_c   = gnt_d_c & d_we_i;
    tgt_c     = TGT_NONE;
    err_c     = 1'b0;
    if (any_gnt_c) begin
      if ((region_of(addr_c) == RAM_REGION) && (gnt_d_c || (addr_c[1:0] == 2'b00))) begin
        tgt_c = TGT_RAM;
      end else if ((region_of(addr_c) == FIFO_REGION) && gnt_d_c) begin
        tgt_c = TGT_FIFO;
      end else begin
        err_c = 1'b1;
      end
    end
  end

  // Bits outside the decoded fields are intentionally ignored (aliasing)
  assign unused_addr_c = ^addr_c;

  // Slave strobes driven in the acceptance cycle, quiet when not selected
  always_comb begin
    i_gnt_o      = gnt_i_c;
    d_gnt_o      = gnt_d_c;
    ram_en_o     = 1'b0;
    ram_we_o     = '0;
    ram_addr_o   = '0;
    ram_wdata_o  = '0;
    fifo_sel_o   = 1'b0;
    fifo_read_o  = 1'b0;
    fifo_write_o = 1'b0;
    fifo_addr_o  = '0;
    fifo_data_o  = '0;
    if (tgt_c == TGT_RAM) begin
      ram_en_o   = 1'b1;
      ram_addr_o = addr_c[RAM_AW+1:2];
      if (store_c) begin
        ram_we_o    = d_be_i;
        ram_wdata_o = d_wdata_i;
      end
    end
    if (tgt_c == TGT_FIFO) begin
      fifo_sel_o   = 1'b1;
      fifo_addr_o  = addr_c[3:2];
      fifo_read_o  = ~store_c;
      fifo_write_o = store_c & d_be_i[0];
      if (store_c) begin
        fifo_data_o = d_wdata_i[FIFO_DW-1:0];
      end
    end
  end

  // Next response entry; stores carry no data source
  always_comb begin
    rsp_d = '0;
    if (any_gnt_c) begin
      rsp_d.valid  = 1'b1;
      rsp_d.master = gnt_d_c ? GNT_DATA : GNT_INSTR;
      rsp_d.target = store_c ? TGT_NONE : tgt_c;
      rsp_d.err    = err_c;
    end
  end

  // Arbitration history and response register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      last_gnt_q <= GNT_INSTR;
      rsp_q      <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      rsp_q      <= rsp_d;
    end
  end

  // Response steering to the master that issued the accepted request
  always_comb begin
    unique case (rsp_q.target)
      TGT_RAM:  rsp_data_c = ram_rdata_i;
      TGT_FIFO: rsp_data_c = {(DATA_W-FIFO_DW)'(0), fifo_data_i};
      default:  rsp_data_c = '0;
    endcase
    i_rvalid_o = rsp_q.valid & (rsp_q.master == GNT_INSTR);
    d_rvalid_o = rsp_q.valid & (rsp_q.master == GNT_DATA);
    i_rdata_o  = i_rvalid_o ? rsp_data_c : '0;
    d_rdata_o  = d_rvalid_o ? rsp_data_c : '0;
    i_err_o    = i_rvalid_o & rsp_q.err;
    d_err_o    = d_rvalid_o & rsp_q.err;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter with a behavioural RAM slave.
module tb_bus_arbiter;

  localparam int unsigned RAM_AW = 10;

  typedef struct packed {
    logic        port;   // 0 = fetch, 1 = data
    logic [31:0] data;
    logic        err;
  } exp_rsp_t;

  logic              clk, rstn;
  logic              i_req, i_gnt, i_rvalid, i_err;
  logic [31:0]       i_addr, i_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]        d_be;
  logic [31:0]       d_addr, d_wdata, d_rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic              fifo_sel, fifo_read, fifo_write;
  logic [1:0]        fifo_addr;
  logic [7:0]        fifo_dout, fifo_din;

  logic [31:0] mem     [0:(1<<RAM_AW)-1];
  logic [31:0] exp_mem [0:(1<<RAM_AW)-1];

  exp_rsp_t q[$];
  int       checks = 0;
  int       errors = 0;
  logic     tb_last = 1'b0;
  logic     last_dg;
  logic [3:0] seq;

  bus_arbiter #(.RAM_AW(RAM_AW), .RAM_REGION(4'h0), .FIFO_REGION(4'h8)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt),
    .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata), .i_err_o(i_err),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
    .d_rdata_o(d_rdata), .d_err_o(d_err),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .fifo_sel_o(fifo_sel), .fifo_read_o(fifo_read), .fifo_write_o(fifo_write),
    .fifo_addr_o(fifo_addr), .fifo_data_o(fifo_dout), .fifo_data_i(fifo_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM slave: data valid the cycle after ram_en
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, 32'({i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, ram_en, ram_we,
                            fifo_sel, fifo_read, fifo_write}), 32'd0);
    chk({tag, "_data"}, i_rdata | d_rdata, 32'd0);
  endtask

  // Compare the registered response against the scoreboard head
  task automatic check_rsp();
    exp_rsp_t e;
    logic     has;
    has = (q.size() > 0);
    e   = '0;
    if (has) e = q.pop_front();
    chk("i_rvalid", 32'(i_rvalid), 32'(has && !e.port));
    chk("i_rdata",  i_rdata, (has && !e.port) ? e.data : 32'd0);
    if (has && !e.port) chk("i_err", 32'(i_err), 32'(e.err));
    chk("d_rvalid", 32'(d_rvalid), 32'(has && e.port));
    chk("d_rdata",  d_rdata, (has && e.port) ? e.data : 32'd0);
    if (has && e.port) chk("d_err", 32'(d_err), 32'(e.err));
  endtask

  // One bus cycle: drive at negedge, check strobes, check response after edge
  task automatic step(input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw, input logic [3:0] dbe,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [7:0] fd);
    logic        eg_i, eg_d, st, e_err;
    logic [1:0]  tgt;
    logic [31:0] a, ed;
    i_req = ir; i_addr = ia;
    d_req = dr; d_we = dw; d_be = dbe; d_addr = da; d_wdata = dwd;
    fifo_din = fd;
    #1;
    eg_d = dr && (!ir || (tb_last == 1'b0));
    eg_i = ir && !eg_d;
    if (ir && dr) tb_last = eg_d;
    chk("i_gnt", 32'(i_gnt), 32'(eg_i));
    chk("d_gnt", 32'(d_gnt), 32'(eg_d));
    last_dg = d_gnt;
    a     = eg_d ? da : ia;
    st    = eg_d && dw;
    tgt   = 2'd0;
    e_err = 1'b0;
    if (eg_i || eg_d) begin
      if (a[31:28] == 4'h0 && (eg_d || a[1:0] == 2'b00)) tgt = 2'd1;
      else if (a[31:28] == 4'h8 && eg_d)                  tgt = 2'd2;
      else                                                 e_err = 1'b1;
    end
    chk("ram_en", 32'(ram_en), 32'(tgt == 2'd1));
    chk("ram_we", 32'(ram_we), (tgt == 2'd1 && st) ? 32'(dbe) : 32'd0);
    if (tgt == 2'd1) chk("ram_addr", 32'(ram_addr), 32'(a[11:2]));
    if (tgt == 2'd1 && st) chk("ram_wdata", ram_wdata, dwd);
    chk("fifo_sel",   32'(fifo_sel),   32'(tgt == 2'd2));
    chk("fifo_read",  32'(fifo_read),  32'(tgt == 2'd2 && !st));
    chk("fifo_write", 32'(fifo_write), 32'(tgt == 2'd2 && st && dbe[0]));
    if (tgt == 2'd2) chk("fifo_addr", 32'(fifo_addr), 32'(a[3:2]));
    if (tgt == 2'd2 && st && dbe[0]) chk("fifo_data", 32'(fifo_dout), 32'(dwd[7:0]));
    ed = 32'd0;
    if (!st && tgt == 2'd1) ed = exp_mem[a[11:2]];
    if (!st && tgt == 2'd2) ed = {24'd0, fd};
    if (st && tgt == 2'd1) begin
      for (int b = 0; b < 4; b++) begin
        if (dbe[b]) exp_mem[a[11:2]][8*b +: 8] = dwd[8*b +: 8];
      end
    end
    if (eg_i || eg_d) q.push_back('{port: eg_d, data: ed, err: e_err});
    @(posedge clk);
    #1;
    check_rsp();
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 8'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << RAM_AW); i++) begin
      mem[i]     = 32'h1000_0000 + 32'(i);
      exp_mem[i] = 32'h1000_0000 + 32'(i);
    end
    mem[4] = 32'hDEAD_BEEF; exp_mem[4] = 32'hDEAD_BEEF;
    ram_rdata = 32'd0;
    rstn = 1'b0;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    fifo_din = 0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Contention: round-robin starting with data
    seq = 4'd0;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 32'h0000_0010, 1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'd0, 8'd0);
      seq = {seq[2:0], last_dg};
    end
    chk("rr_seq", 32'(seq), 32'h0000_000A);

    // Fetch, store, load-back
    step(1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 8'd0);
    idle();
    step(1'b0, 32'd0, 1'b1, 1'b1, 4'b0011, 32'h0000_0008, 32'h1234_5678, 8'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h0000_0008, 32'd0, 8'd0);

    // fifo_if register accesses
    step(1'b0, 32'd0, 1'b1, 1'b1, 4'h1, 32'h8000_0004, 32'h0000_0041, 8'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h8000_0000, 32'd0, 8'h5A);
    step(1'b0, 32'd0, 1'b1, 1'b1, 4'b1110, 32'h8000_0ABF, 32'hFFFF_FF77, 8'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h8765_432C, 32'd0, 8'hA5);

    // Error cases
    step(1'b1, 32'h8000_0000, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 8'h33);
    step(1'b1, 32'h0000_0002, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0, 8'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h3000_0000, 32'd0, 8'd0);
    step(1'b0, 32'd0, 1'b1, 1'b1, 4'hF, 32'hF000_0010, 32'hCAFE_F00D, 8'd0);

    // Aliasing and unaligned data access to RAM are legal
    step(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h0000_1010, 32'd0, 8'd0);
    step(1'b0, 32'd0, 1'b1, 1'b0, 4'hF, 32'h0000_0013, 32'd0, 8'd0);

    // Randomised back-to-back traffic
    for (int k = 0; k < 40; k++) begin
      logic [31:0] ia, da;
      case ($urandom_range(0, 3))
        0: ia = 32'h0000_0010;
        1: ia = 32'h0000_0014;
        2: ia = 32'h8000_0000;
        default: ia = 32'h0000_0002;
      endcase
      case ($urandom_range(0, 3))
        0: da = 32'h0000_0020;
        1: da = 32'h8000_0008;
        2: da = 32'h5000_0000;
        default: da = 32'h0000_0024;
      endcase
      step(1'($urandom_range(0, 1)), ia, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           4'($urandom), da, $urandom, 8'($urandom));
    end

    // Reset during a pending response drops it
    i_req = 1'b1; i_addr = 32'h0000_0010;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0020;
    @(posedge clk);
    #1;
    chk("pending_rvalid", 32'(i_rvalid | d_rvalid), 32'd1);
    rstn = 1'b0;
    #1;
    check_zero("mid_reset");
    q.delete();
    tb_last = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    idle();
    idle();
    step(1'b1, 32'h0000_0010, 1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'd0, 8'd0);
    chk("post_reset_first_gnt", 32'(last_dg), 32'd1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one memory/peripheral bus between two requesters: the instruction-fetch port and the load/store data port.
- Decodes each accepted address to one of two targets: the synchronous program/data RAM, or the fifo_if register interface.
- Returns read data one cycle after acceptance. Throughput is one transaction per cycle.
- Sits between the control/LSU logic and the memories in the cpu top level. It replaces the tied-off fifo_sel/read/write/addr/data drive in cpu.

Parameters:
- RAM_AW, 10: RAM word-address width. RAM size is 4*2^RAM_AW bytes.
- RAM_REGION, 4'h0: value of addr[31:28] that selects the RAM.
- FIFO_REGION, 4'h8: value of addr[31:28] that selects the fifo_if registers.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset. Asynchronous, active-low.
- i_req_i  in  1  fetch request
- i_addr_i  in  32  fetch byte address
- i_gnt_o  out  1  fetch accepted this cycle
- i_rvalid_o  out  1  fetch response valid
- i_rdata_o  out  32  fetch data
- i_err_o  out  1  fetch error, qualified by i_rvalid_o
- d_req_i  in  1  data request
- d_we_i  in  1  1 = store
- d_be_i  in  4  byte enables
- d_addr_i  in  32  data byte address
- d_wdata_i  in  32  store data
- d_gnt_o  out  1  data accepted this cycle
- d_rvalid_o  out  1  data response valid (asserted for loads and stores)
- d_rdata_o  out  32  load data
- d_err_o  out  1  data error, qualified by d_rvalid_o
- ram_en_o  out  1  RAM access strobe
- ram_we_o  out  4  RAM byte write enables
- ram_addr_o  out  RAM_AW  RAM word address
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data, valid the cycle after ram_en_o
- fifo_sel_o  out  1  fifo_if select
- fifo_read_o  out  1  fifo_if read strobe
- fifo_write_o  out  1  fifo_if write strobe
- fifo_addr_o  out  2  fifo_if register index (= addr[3:2])
- fifo_data_o  out  8  fifo_if write data (= wdata[7:0])
- fifo_data_i  in  8  fifo_if read data, valid the cycle after fifo_read_o

Behaviour:
- Reset values: all outputs 0; internal state cleared. last_gnt resets to INSTR, so the first contended cycle grants DATA.
- Grant (combinational, every cycle):
  - One requester active: that requester is granted.
  - Both active: the requester not granted on the last contended cycle wins (round-robin). last_gnt updates only on contended cycles.
  - Exactly one gnt per cycle at most; never a gnt without the matching req.
- Acceptance: a transaction is accepted on req && gnt in cycle N. Slave strobes are driven combinationally in cycle N from the granted request.
- Decode on addr[31:28]:
  - RAM_REGION → RAM. ram_en_o = 1, ram_addr_o = addr[RAM_AW+1:2].
    - ram_we_o = d_be_i for a data store; 0 for loads and fetches.
  - FIFO_REGION, data port only → fifo_sel_o = 1.
    - Load: fifo_read_o = 1.
    - Store: fifo_write_o = d_be_i[0].
    - A store with be[0] = 0 completes without error and without a write.
  - Anything else, a fetch to FIFO_REGION, or a fetch with addr[1:0] != 0 → error. No slave strobe is driven.
- Response register (1 entry): captures {valid, master, target, err} at acceptance.
  - Cycle N+1: the matching rvalid = 1 for exactly one cycle.
  - rdata = ram_rdata_i for the RAM target; {24'b0, fifo_data_i} for the FIFO target; 0 for stores and errors.
  - err flag as captured.
  - The non-matching port keeps rvalid = 0 and rdata = 0.
- Pipelining: a new acceptance may occur in cycle N+1 while the response for N is presented. No back-pressure on responses; requesters must accept rvalid.
- Idle cycle (no req): response register goes invalid next cycle; no slave strobe.
- Reset asserted mid-transaction: the pending response is dropped. No rvalid appears after reset release until a new acceptance.
- Width rules:
  - Addresses above the RAM size inside RAM_REGION alias (upper bits ignored); this is not an error.
  - fifo_addr_o ignores addr[1:0] and addr[27:4].

Decomposition:
- Shared const.v additions: the region constants and the master encodings (GNT_INSTR = 1'b0, GNT_DATA = 1'b1).
- Target encodings: TGT_RAM, TGT_FIFO, TGT_NONE.
- No sub-module. Decode and round-robin grant are small enough to stay inline; the response register lives in the same file.

Test Plan:
- Fetch only: i_req at 0x0000_0010, RAM word 4 = 0xDEADBEEF → i_gnt same cycle, ram_addr = 4, ram_en; next cycle i_rvalid = 1, i_rdata = 0xDEADBEEF, i_err = 0.
- Contention: i_req and d_req held high 4 cycles, both at RAM → grants alternate D, I, D, I. Each response arrives one cycle later on the correct port; no duplicate rvalid.
- Data store to RAM: d_addr = 0x0000_0008, be = 4'b0011, wdata = 0x12345678 → ram_we = 4'b0011, ram_addr = 2, wdata passed through; next cycle d_rvalid = 1, d_rdata = 0.
- FIFO access: d store to 0x8000_0004 with wdata 0x41 → fifo_sel = 1, fifo_write = 1, fifo_addr = 1, fifo_data = 0x41. Then a load from 0x8000_0000 with fifo_data_i = 0x5A → d_rdata = 0x0000_005A next cycle.
- Errors:
  - i_req at 0x8000_0000 → no fifo/ram strobe; i_rvalid = 1, i_err = 1.
  - i_req at 0x0000_0002 → i_err = 1.
  - d_req at 0x3000_0000 → d_err = 1, d_rdata = 0.
- Reset mid-flight: accept a load, assert rstn_i low in the following cycle before the clock edge → all outputs 0 immediately; after release, no rvalid until a new request.
